// File: rtl/alu_rs.sv
// Reservation station for the single ALU: buffers dispatched ops, wakes them from
// the ALU/LSB CDBs and issues the lowest-index ready entry once per cycle.
module alu_rs #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clear,
  input  logic             dsp_sgn,
  input  logic [5:0]       dsp_opcode,
  input  logic [31:0]      dsp_vj,
  input  logic [31:0]      dsp_vk,
  input  logic [ROB_W-1:0] dsp_qj,
  input  logic [ROB_W-1:0] dsp_qk,
  input  logic             dsp_qj_busy,
  input  logic             dsp_qk_busy,
  input  logic [31:0]      dsp_imm,
  input  logic [31:0]      dsp_pc,
  input  logic [ROB_W-1:0] dsp_rob,
  output logic             rs_full,
  input  logic             alu_cdb_sgn,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_sgn,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_val,
  output logic             RS_sgn,
  output logic [5:0]       RS_opcode,
  output logic [31:0]      lhs,
  output logic [31:0]      rhs,
  output logic [31:0]      imm,
  output logic [31:0]      pc,
  output logic [ROB_W-1:0] ROB_entry
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);

  typedef struct packed {
    logic             valid;
    logic [5:0]       opcode;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [ROB_W-1:0] qj;
    logic [ROB_W-1:0] qk;
    logic             qj_busy;
    logic             qk_busy;
    logic [31:0]      imm;
    logic [31:0]      pc;
    logic [ROB_W-1:0] rob;
  } entry_t;

  entry_t           ent_q [RS_SIZE];
  entry_t           ent_d [RS_SIZE];
  entry_t           new_ent;
  logic             iss_found, free_found;
  logic [IDX_W-1:0] iss_idx, free_idx;

  logic             sgn_q, sgn_d;
  logic [5:0]       op_q, op_d;
  logic [31:0]      lhs_q, lhs_d, rhs_q, rhs_d, imm_q, imm_d, pc_q, pc_d;
  logic [ROB_W-1:0] rob_q, rob_d;

  // Operand capture from the CDBs; ALU bus has priority on a shared tag.
  function automatic logic [32:0] wake(input logic busy, input logic [ROB_W-1:0] tag,
                                       input logic [31:0] val,
                                       input logic a_sgn, input logic [ROB_W-1:0] a_rob,
                                       input logic [31:0] a_val,
                                       input logic l_sgn, input logic [ROB_W-1:0] l_rob,
                                       input logic [31:0] l_val);
    logic [32:0] r;
    r = {busy, val};
    if (busy && a_sgn && a_rob == tag)      r = {1'b0, a_val};
    else if (busy && l_sgn && l_rob == tag) r = {1'b0, l_val};
    return r;
  endfunction

  // Lowest-index ready and free slots, from registered state only.
  always_comb begin
    iss_found  = 1'b0;
    iss_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!iss_found && ent_q[i].valid && !ent_q[i].qj_busy && !ent_q[i].qk_busy) begin
        iss_found = 1'b1;
        iss_idx   = IDX_W'(i);
      end
      if (!free_found && !ent_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign rs_full = ~free_found;

  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        {ent_d[i].qj_busy, ent_d[i].vj} = wake(ent_q[i].qj_busy, ent_q[i].qj, ent_q[i].vj,
          alu_cdb_sgn, alu_cdb_rob, alu_cdb_val, lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_val);
        {ent_d[i].qk_busy, ent_d[i].vk} = wake(ent_q[i].qk_busy, ent_q[i].qk, ent_q[i].vk,
          alu_cdb_sgn, alu_cdb_rob, alu_cdb_val, lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_val);
      end
    end

    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.opcode = dsp_opcode;
    new_ent.qj     = dsp_qj;
    new_ent.qk     = dsp_qk;
    new_ent.imm    = dsp_imm;
    new_ent.pc     = dsp_pc;
    new_ent.rob    = dsp_rob;
    {new_ent.qj_busy, new_ent.vj} = wake(dsp_qj_busy, dsp_qj, dsp_vj,
      alu_cdb_sgn, alu_cdb_rob, alu_cdb_val, lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_val);
    {new_ent.qk_busy, new_ent.vk} = wake(dsp_qk_busy, dsp_qk, dsp_vk,
      alu_cdb_sgn, alu_cdb_rob, alu_cdb_val, lsb_cdb_sgn, lsb_cdb_rob, lsb_cdb_val);

    if (iss_found) ent_d[iss_idx].valid = 1'b0;
    if (dsp_sgn && free_found) ent_d[free_idx] = new_ent;
    if (clear) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) ent_d[i].valid = 1'b0;
    end

    // Issue payload holds its last value when nothing issues.
    sgn_d = iss_found && !clear;
    op_d  = op_q;
    lhs_d = lhs_q;
    rhs_d = rhs_q;
    imm_d = imm_q;
    pc_d  = pc_q;
    rob_d = rob_q;
    if (sgn_d) begin
      op_d  = ent_q[iss_idx].opcode;
      lhs_d = ent_q[iss_idx].vj;
      rhs_d = ent_q[iss_idx].vk;
      imm_d = ent_q[iss_idx].imm;
      pc_d  = ent_q[iss_idx].pc;
      rob_d = ent_q[iss_idx].rob;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
      sgn_q <= 1'b0;
      op_q  <= '0;
      lhs_q <= '0;
      rhs_q <= '0;
      imm_q <= '0;
      pc_q  <= '0;
      rob_q <= '0;
    end else if (rdy) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
      sgn_q <= sgn_d;
      op_q  <= op_d;
      lhs_q <= lhs_d;
      rhs_q <= rhs_d;
      imm_q <= imm_d;
      pc_q  <= pc_d;
      rob_q <= rob_d;
    end
  end

  assign RS_sgn    = sgn_q;
  assign RS_opcode = op_q;
  assign lhs       = lhs_q;
  assign rhs       = rhs_q;
  assign imm       = imm_q;
  assign pc        = pc_q;
  assign ROB_entry = rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios then random traffic, every cycle compared
// against a slot-array model of the station.
module tb_alu_rs;

  logic        clk, rst, rdy, clear;
  logic        dsp_sgn, dsp_qj_busy, dsp_qk_busy;
  logic [5:0]  dsp_opcode;
  logic [31:0] dsp_vj, dsp_vk, dsp_imm, dsp_pc;
  logic [3:0]  dsp_qj, dsp_qk, dsp_rob;
  logic        rs_full;
  logic        alu_cdb_sgn, lsb_cdb_sgn;
  logic [3:0]  alu_cdb_rob, lsb_cdb_rob;
  logic [31:0] alu_cdb_val, lsb_cdb_val;
  logic        RS_sgn;
  logic [5:0]  RS_opcode;
  logic [31:0] lhs, rhs, imm, pc;
  logic [3:0]  ROB_entry;

  alu_rs dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .dsp_sgn(dsp_sgn), .dsp_opcode(dsp_opcode), .dsp_vj(dsp_vj), .dsp_vk(dsp_vk),
    .dsp_qj(dsp_qj), .dsp_qk(dsp_qk), .dsp_qj_busy(dsp_qj_busy), .dsp_qk_busy(dsp_qk_busy),
    .dsp_imm(dsp_imm), .dsp_pc(dsp_pc), .dsp_rob(dsp_rob), .rs_full(rs_full),
    .alu_cdb_sgn(alu_cdb_sgn), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_sgn(lsb_cdb_sgn), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
    .RS_sgn(RS_sgn), .RS_opcode(RS_opcode), .lhs(lhs), .rhs(rhs), .imm(imm), .pc(pc),
    .ROB_entry(ROB_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd10;

  // Pending operand is a ROB tag (>=0); -1 means the value is already held.
  typedef struct {
    bit          valid;
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
    logic [3:0]  rob;
    int          pj, pk;
  } m_ent_t;

  m_ent_t      m [8];
  logic        e_sgn;
  logic [5:0]  e_op;
  logic [31:0] e_lhs, e_rhs, e_imm, e_pc;
  logic [3:0]  e_rob;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_val(input int p, input logic [31:0] v);
    if (p >= 0 && alu_cdb_sgn && int'(alu_cdb_rob) == p) return alu_cdb_val;
    if (p >= 0 && lsb_cdb_sgn && int'(lsb_cdb_rob) == p) return lsb_cdb_val;
    return v;
  endfunction

  function automatic int got_tag(input int p);
    if (p >= 0 && alu_cdb_sgn && int'(alu_cdb_rob) == p) return -1;
    if (p >= 0 && lsb_cdb_sgn && int'(lsb_cdb_rob) == p) return -1;
    return p;
  endfunction

  // Advance the model by one clock using the inputs presented at this edge.
  task automatic model_edge();
    int k, f;
    if (rst) begin
      foreach (m[i]) m[i].valid = 1'b0;
      e_sgn = 0; e_op = 0; e_lhs = 0; e_rhs = 0; e_imm = 0; e_pc = 0; e_rob = 0;
    end else if (rdy) begin
      if (clear) begin
        foreach (m[i]) m[i].valid = 1'b0;
        e_sgn = 1'b0;
      end else begin
        k = -1;
        f = -1;
        foreach (m[i]) begin
          if (k < 0 && m[i].valid && m[i].pj < 0 && m[i].pk < 0) k = i;
          if (f < 0 && !m[i].valid) f = i;
        end
        e_sgn = (k >= 0);
        if (k >= 0) begin
          e_op = m[k].op; e_lhs = m[k].vj; e_rhs = m[k].vk;
          e_imm = m[k].imm; e_pc = m[k].pc; e_rob = m[k].rob;
          m[k].valid = 1'b0;
        end
        foreach (m[i]) begin
          if (m[i].valid) begin
            m[i].vj = got_val(m[i].pj, m[i].vj); m[i].pj = got_tag(m[i].pj);
            m[i].vk = got_val(m[i].pk, m[i].vk); m[i].pk = got_tag(m[i].pk);
          end
        end
        if (dsp_sgn && f >= 0) begin
          m[f].valid = 1'b1;
          m[f].op = dsp_opcode; m[f].imm = dsp_imm; m[f].pc = dsp_pc; m[f].rob = dsp_rob;
          m[f].pj = dsp_qj_busy ? int'(dsp_qj) : -1;
          m[f].pk = dsp_qk_busy ? int'(dsp_qk) : -1;
          m[f].vj = got_val(m[f].pj, dsp_vj); m[f].pj = got_tag(m[f].pj);
          m[f].vk = got_val(m[f].pk, dsp_vk); m[f].pk = got_tag(m[f].pk);
        end
      end
    end
  endtask

  task automatic step();
    bit full;
    @(posedge clk);
    model_edge();
    #1;
    full = 1'b1;
    foreach (m[i]) if (!m[i].valid) full = 1'b0;
    chk("sgn", 32'(RS_sgn), 32'(e_sgn));
    chk("full", 32'(rs_full), 32'(full));
    chk("op", 32'(RS_opcode), 32'(e_op));
    chk("lhs", lhs, e_lhs);
    chk("rhs", rhs, e_rhs);
    chk("imm", imm, e_imm);
    chk("pc", pc, e_pc);
    chk("rob", 32'(ROB_entry), 32'(e_rob));
    dsp_sgn = 1'b0; alu_cdb_sgn = 1'b0; lsb_cdb_sgn = 1'b0; clear = 1'b0;
  endtask

  task automatic put(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input int pj, input int pk, input logic [31:0] im,
                     input logic [31:0] p, input logic [3:0] rob);
    dsp_sgn = 1'b1; dsp_opcode = op; dsp_vj = vj; dsp_vk = vk;
    dsp_qj_busy = (pj >= 0); dsp_qj = (pj >= 0) ? 4'(pj) : 4'd0;
    dsp_qk_busy = (pk >= 0); dsp_qk = (pk >= 0) ? 4'(pk) : 4'd0;
    dsp_imm = im; dsp_pc = p; dsp_rob = rob;
  endtask

  initial begin
    total = 0; bad = 0;
    foreach (m[i]) m[i] = '{valid: 1'b0, op: 6'd0, vj: 32'd0, vk: 32'd0, imm: 32'd0,
                             pc: 32'd0, rob: 4'd0, pj: -1, pk: -1};
    e_sgn = 0; e_op = 0; e_lhs = 0; e_rhs = 0; e_imm = 0; e_pc = 0; e_rob = 0;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0;
    put(OP_ADD, 32'h1, 32'h2, -1, -1, 32'h3, 32'h4, 4'h5);
    alu_cdb_sgn = 1'b0; alu_cdb_rob = 0; alu_cdb_val = 0;
    lsb_cdb_sgn = 1'b0; lsb_cdb_rob = 0; lsb_cdb_val = 0;

    // Reset
    step(); step();
    chk("rst_sgn", 32'(RS_sgn), 32'd0);
    chk("rst_full", 32'(rs_full), 32'd0);
    chk("rst_lhs", lhs, 32'd0);
    chk("rst_rob", 32'(ROB_entry), 32'd0);
    rst = 1'b0;

    // Ready ADDI issues two edges after dispatch
    put(OP_ADDI, 32'd5, 32'hDEAD, -1, -1, 32'd3, 32'h100, 4'd2);
    step();
    chk("t2_wait", 32'(RS_sgn), 32'd0);
    step();
    chk("t2_sgn", 32'(RS_sgn), 32'd1);
    chk("t2_lhs", lhs, 32'd5);
    chk("t2_imm", imm, 32'd3);
    chk("t2_rob", 32'(ROB_entry), 32'd2);

    // Wakeup from ALU CDB
    put(OP_ADD, 32'd0, 32'd7, 4, -1, 32'd0, 32'h104, 4'd3);
    step(); step();
    alu_cdb_sgn = 1'b1; alu_cdb_rob = 4'd4; alu_cdb_val = 32'd10;
    step();
    chk("t3_wait", 32'(RS_sgn), 32'd0);
    step();
    chk("t3_sgn", 32'(RS_sgn), 32'd1);
    chk("t3_lhs", lhs, 32'd10);
    chk("t3_rhs", rhs, 32'd7);

    // Fill all slots, wake 5 and 2 together
    for (int i = 0; i < 8; i++) begin
      put(OP_ADD, 32'd0, 32'(i), 8 + i, -1, 32'(i), 32'h200 + 32'(4 * i), 4'(i));
      step();
    end
    chk("t4_full", 32'(rs_full), 32'd1);
    alu_cdb_sgn = 1'b1; alu_cdb_rob = 4'd13; alu_cdb_val = 32'h55;
    lsb_cdb_sgn = 1'b1; lsb_cdb_rob = 4'd10; lsb_cdb_val = 32'h22;
    step();
    chk("t4_wake", 32'(RS_sgn), 32'd0);
    step();
    chk("t4_first", 32'(ROB_entry), 32'd2);
    chk("t4_first_lhs", lhs, 32'h22);
    chk("t4_unfull", 32'(rs_full), 32'd0);
    step();
    chk("t4_second", 32'(ROB_entry), 32'd5);
    chk("t4_second_lhs", lhs, 32'h55);

    // Flush drops everything, including same-cycle dispatch and CDB
    clear = 1'b1;
    put(OP_ADDI, 32'd1, 32'd1, -1, -1, 32'd1, 32'h300, 4'd9);
    alu_cdb_sgn = 1'b1; alu_cdb_rob = 4'd8; alu_cdb_val = 32'h1;
    step();
    chk("t6_clr_sgn", 32'(RS_sgn), 32'd0);
    chk("t6_clr_full", 32'(rs_full), 32'd0);
    alu_cdb_sgn = 1'b1; alu_cdb_rob = 4'd9; alu_cdb_val = 32'h2;
    step(); step();
    chk("t6_clr_idle", 32'(RS_sgn), 32'd0);

    // Same-cycle bypass from LSB CDB
    put(OP_ADD, 32'h11, 32'd0, -1, 6, 32'd0, 32'h400, 4'd7);
    lsb_cdb_sgn = 1'b1; lsb_cdb_rob = 4'd6; lsb_cdb_val = 32'hFFFF_0000;
    step();
    chk("t5_wait", 32'(RS_sgn), 32'd0);
    step();
    chk("t5_sgn", 32'(RS_sgn), 32'd1);
    chk("t5_rhs", rhs, 32'hFFFF_0000);

    // Stall with a ready entry
    put(OP_ADDI, 32'd9, 32'd0, -1, -1, 32'd4, 32'h500, 4'd1);
    step();
    rdy = 1'b0;
    put(OP_ADDI, 32'd8, 32'd0, -1, -1, 32'd4, 32'h504, 4'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stall", 32'(RS_sgn), 32'd0);
    end
    rdy = 1'b1;
    step();
    chk("t6_resume", 32'(RS_sgn), 32'd1);
    chk("t6_resume_lhs", lhs, 32'd9);
    step();
    chk("t6_ignored", 32'(RS_sgn), 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rdy   = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1)
        put(6'($urandom_range(0, 37)), $urandom, $urandom,
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1,
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : -1,
            $urandom, $urandom, 4'($urandom_range(0, 15)));
      alu_cdb_sgn = ($urandom_range(0, 1) == 1);
      alu_cdb_rob = 4'($urandom_range(0, 15));
      alu_cdb_val = $urandom;
      lsb_cdb_sgn = ($urandom_range(0, 1) == 1);
      lsb_cdb_rob = ($urandom_range(0, 9) == 0) ? alu_cdb_rob : 4'($urandom_range(0, 15));
      lsb_cdb_val = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
